// File: rtl/cnt_seq_checker.sv
// Receive-side checker for a free-running counter bus: acquires lock on a run of
// +1 steps, then reports sequence errors and max->0 wraps while locked.
module cnt_seq_checker #(
    parameter int WIDTH       = 4,
    parameter int LOCK_CNT    = 4,
    parameter int UNLOCK_ERRS = 2,
    parameter int STAT_W      = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [WIDTH-1:0]  cnt_in,
    input  logic              cnt_vld,
    input  logic              clr,
    output logic              locked,
    output logic              err_pulse,
    output logic              wrap_pulse,
    output logic [STAT_W-1:0] err_count,
    output logic [STAT_W-1:0] wrap_count
);

    localparam int GR_W = $clog2(LOCK_CNT + 1);
    localparam int BR_W = $clog2(UNLOCK_ERRS + 1);
    localparam logic [GR_W-1:0] LOCK_V   = GR_W'(LOCK_CNT);
    localparam logic [BR_W-1:0] UNLOCK_V = BR_W'(UNLOCK_ERRS);

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        LOCK
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  last;
    logic [GR_W-1:0]   good_run;
    logic [BR_W-1:0]   bad_run;

    logic [WIDTH-1:0]  last_inc;
    logic              good_step;
    logic              last_is_max;
    logic [GR_W-1:0]   good_run_inc;
    logic [BR_W-1:0]   bad_run_inc;

    // Truncation to WIDTH bits makes the max->0 step count as good.
    assign last_inc     = last + 1'b1;
    assign good_step    = (cnt_in == last_inc);
    assign last_is_max  = (last == '1);
    assign good_run_inc = good_run + 1'b1;
    assign bad_run_inc  = bad_run + 1'b1;

    // NOTE: every register here is updated with <= so all branches see the
    // pre-edge values of state/last/run counters, independent of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            last       <= '0;
            good_run   <= '0;
            bad_run    <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            err_count  <= '0;
            wrap_count <= '0;
        end else begin
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            if (clr) begin
                state      <= IDLE;
                last       <= '0;
                good_run   <= '0;
                bad_run    <= '0;
                locked     <= 1'b0;
                err_count  <= '0;
                wrap_count <= '0;
            end else if (cnt_vld) begin
                last <= cnt_in;
                case (state)
                    IDLE: begin
                        good_run <= '0;
                        state    <= ACQ;
                    end
                    ACQ: begin
                        if (good_step) begin
                            good_run <= good_run_inc;
                            if (good_run_inc == LOCK_V) begin
                                state   <= LOCK;
                                locked  <= 1'b1;
                                bad_run <= '0;
                            end
                        end else begin
                            good_run <= '0;
                        end
                    end
                    LOCK: begin
                        if (good_step) begin
                            bad_run <= '0;
                            if (last_is_max) begin
                                wrap_pulse <= 1'b1;
                                wrap_count <= wrap_count + 1'b1;
                            end
                        end else begin
                            err_pulse <= 1'b1;
                            if (err_count != '1) begin
                                err_count <= err_count + 1'b1;
                            end
                            bad_run <= bad_run_inc;
                            // Lock drops on the same edge that pulses the last error.
                            if (bad_run_inc == UNLOCK_V) begin
                                state    <= ACQ;
                                locked   <= 1'b0;
                                good_run <= '0;
                            end
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cnt_seq_checker.sv
// Directed self-checking bench for cnt_seq_checker (WIDTH=4, LOCK_CNT=4,
// UNLOCK_ERRS=2, STAT_W=8).
module tb_cnt_seq_checker;

    logic       clk;
    logic       rstn;
    logic [3:0] cnt_in;
    logic       cnt_vld;
    logic       clr;
    logic       locked;
    logic       err_pulse;
    logic       wrap_pulse;
    logic [7:0] err_count;
    logic [7:0] wrap_count;

    int checks;
    int errors;

    cnt_seq_checker #(
        .WIDTH      (4),
        .LOCK_CNT   (4),
        .UNLOCK_ERRS(2),
        .STAT_W     (8)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cnt_in    (cnt_in),
        .cnt_vld   (cnt_vld),
        .clr       (clr),
        .locked    (locked),
        .err_pulse (err_pulse),
        .wrap_pulse(wrap_pulse),
        .err_count (err_count),
        .wrap_count(wrap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Outputs are compared 1 time unit after the sampling edge.
    task automatic sample(input logic [3:0] v);
        @(negedge clk);
        cnt_in  = v;
        cnt_vld = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        cnt_vld = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic l, input logic e, input logic w,
                             input logic [7:0] ec, input logic [7:0] wc);
        check({tag, ".locked"}, 32'(locked), 32'(l));
        check({tag, ".err_pulse"}, 32'(err_pulse), 32'(e));
        check({tag, ".wrap_pulse"}, 32'(wrap_pulse), 32'(w));
        check({tag, ".err_count"}, 32'(err_count), 32'(ec));
        check({tag, ".wrap_count"}, 32'(wrap_count), 32'(wc));
    endtask

    initial begin
        int exp_err;
        int exp_wrap;
        logic [3:0] p;

        checks  = 0;
        errors  = 0;
        rstn    = 1'b0;
        cnt_in  = '0;
        cnt_vld = 1'b0;
        clr     = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Test 1: 0..15,0,1 continuous; lock after sample 4, one wrap after 15->0
        for (int i = 0; i < 18; i++) begin
            sample(4'(i % 16));
            check($sformatf("t1[%0d].locked", i), 32'(locked), 32'(i >= 4));
            check($sformatf("t1[%0d].wrap_pulse", i), 32'(wrap_pulse), 32'(i == 16));
            check($sformatf("t1[%0d].err_pulse", i), 32'(err_pulse), 32'(0));
        end
        check_all("t1.end", 1'b1, 1'b0, 1'b0, 8'd0, 8'd1);

        // Test 2: align to 4, then 5,6,9,10,11 -> single error, stay locked
        sample(4'd2);
        sample(4'd3);
        sample(4'd4);
        sample(4'd5);
        sample(4'd6);
        check_all("t2.6", 1'b1, 1'b0, 1'b0, 8'd0, 8'd1);
        sample(4'd9);
        check_all("t2.9", 1'b1, 1'b1, 1'b0, 8'd1, 8'd1);
        sample(4'd10);
        check_all("t2.10", 1'b1, 1'b0, 1'b0, 8'd1, 8'd1);
        sample(4'd11);
        check_all("t2.11", 1'b1, 1'b0, 1'b0, 8'd1, 8'd1);

        // Test 3: advance to 2 (one more wrap), then 3,7,1 -> two errors, unlock; relock
        sample(4'd12);
        sample(4'd13);
        sample(4'd14);
        sample(4'd15);
        sample(4'd0);
        check_all("t3.wrap", 1'b1, 1'b0, 1'b1, 8'd1, 8'd2);
        sample(4'd1);
        sample(4'd2);
        sample(4'd3);
        check_all("t3.3", 1'b1, 1'b0, 1'b0, 8'd1, 8'd2);
        sample(4'd7);
        check_all("t3.7", 1'b1, 1'b1, 1'b0, 8'd2, 8'd2);
        sample(4'd1);
        check_all("t3.1", 1'b0, 1'b1, 1'b0, 8'd3, 8'd2);
        sample(4'd2);
        check_all("t3.acq2", 1'b0, 1'b0, 1'b0, 8'd3, 8'd2);
        sample(4'd3);
        sample(4'd4);
        check_all("t3.acq4", 1'b0, 1'b0, 1'b0, 8'd3, 8'd2);
        sample(4'd5);
        check_all("t3.relock", 1'b1, 1'b0, 1'b0, 8'd3, 8'd2);

        // Test 4: alternating bad/good pairs (p, p+1), p += 5 -> saturation at 255
        exp_err  = 3;
        exp_wrap = 2;
        for (int k = 0; k < 300; k++) begin
            p = 4'((5 * k) % 16);
            sample(p);
            exp_err = (exp_err < 255) ? exp_err + 1 : 255;
            check($sformatf("t4[%0d].err_pulse", k), 32'(err_pulse), 32'(1));
            check($sformatf("t4[%0d].err_count", k), 32'(err_count), 32'(exp_err));
            check($sformatf("t4[%0d].locked", k), 32'(locked), 32'(1));
            sample(p + 4'd1);
            if (p == 4'd15) exp_wrap++;
            check($sformatf("t4[%0d].good_err", k), 32'(err_pulse), 32'(0));
            check($sformatf("t4[%0d].wrap_pulse", k), 32'(wrap_pulse), 32'(p == 4'd15));
        end
        check_all("t4.end", 1'b1, 1'b0, 1'b0, 8'd255, 8'(exp_wrap));
        check("t4.wrap_total", 32'(wrap_count), 32'd21);

        // clr without a sample -> everything back to zero
        @(negedge clk);
        cnt_vld = 1'b0;
        clr     = 1'b1;
        @(posedge clk);
        #1;
        check_all("clr", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        @(negedge clk);
        clr = 1'b0;

        // Test 5: vld toggled 1010 with 0..15,0,1 -> same result as test 1
        for (int i = 0; i < 18; i++) begin
            sample(4'(i % 16));
            check($sformatf("t5[%0d].locked", i), 32'(locked), 32'(i >= 4));
            check($sformatf("t5[%0d].wrap_pulse", i), 32'(wrap_pulse), 32'(i == 16));
            idle();
            check($sformatf("t5[%0d].gap_wrap", i), 32'(wrap_pulse), 32'(0));
            check($sformatf("t5[%0d].gap_locked", i), 32'(locked), 32'(i >= 4));
        end
        check_all("t5.end", 1'b1, 1'b0, 1'b0, 8'd0, 8'd1);

        // Test 6a: clr with a sample in the same cycle discards the sample
        @(negedge clk);
        cnt_in  = 4'd2;
        cnt_vld = 1'b1;
        clr     = 1'b1;
        @(posedge clk);
        #1;
        check_all("t6.clr_vld", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        @(negedge clk);
        clr = 1'b0;
        sample(4'd5);
        sample(4'd6);
        sample(4'd7);
        sample(4'd8);
        check("t6.acq_locked", 32'(locked), 32'(0));
        sample(4'd9);
        check("t6.relock", 32'(locked), 32'(1));
        for (int v = 10; v < 17; v++) sample(4'(v % 16));
        check_all("t6.wrap", 1'b1, 1'b0, 1'b1, 8'd0, 8'd1);

        // Test 6b: asynchronous reset mid-LOCK, away from any clock edge
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check_all("t6.async_rst", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        @(negedge clk);
        cnt_vld = 1'b0;
        rstn    = 1'b1;
        idle();
        check_all("t6.post_rst", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
